// File: rtl/bin2bcd_hex_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_hex_seq
//
// Multi-cycle binary-to-BCD converter with an active-low seven-segment driver.
// A WIDTH-bit unsigned value is converted with shift-and-add-3, one bit per
// clock. The results (bcd, HEX, overflow) update only when a conversion
// commits, so they never show intermediate values.
//
// Parameters
//   WIDTH    : input binary width in bits (>= 2)
//   DIGITS   : number of BCD digits / HEX displays produced (>= 1)
//   BLANK_LZ : 1 = blank leading zero displays (display 0 always shown)
//
// Ports
//   Clock    : system clock, all state on the rising edge
//   Reset    : synchronous, active-high reset (priority over start)
//   start    : conversion request, sampled only while idle
//   bin      : unsigned value, captured on the accepting edge
//   busy     : high while a conversion is in progress
//   done     : one-cycle pulse when the outputs update
//   overflow : last captured bin was >= 10^DIGITS
//   bcd      : result digits, digit i at [4i+3:4i], digit 0 = ones
//   HEX      : active-low segments, display i at [7i+6:7i], bit 6 = g
// -----------------------------------------------------------------------------
module bin2bcd_hex_seq #(
   parameter int WIDTH    = 16,
   parameter int DIGITS   = 5,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [7*DIGITS-1:0]   HEX
);

   // Every 3 input bits need less than one decimal digit, so the working
   // register holds the full value even when DIGITS is too small for it.
   localparam int WD = (((WIDTH + 2) / 3) > DIGITS) ? ((WIDTH + 2) / 3) : DIGITS;
   localparam int CW = $clog2(WIDTH + 1);
   localparam int PW = WIDTH + 5;

   // 10^DIGITS, saturated at 2^WIDTH. A saturated limit can never be reached
   // by a WIDTH-bit input, which makes overflow constant 0 in that case.
   function automatic logic [PW-1:0] pow10_sat();
      logic [PW-1:0] p;
      p = PW'(1);
      for (int i = 0; i < DIGITS; i++) begin
         p = p * PW'(10);
         if (p > (PW'(1) << WIDTH))
            p = PW'(1) << WIDTH;
      end
      return p;
   endfunction

   localparam logic [PW-1:0] LIMIT = pow10_sat();

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h18;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

   state_t                state_reg, state_next;
   logic [WIDTH-1:0]      bin_sh_reg;
   logic [4*WD-1:0]       work_reg;
   logic [CW-1:0]         cnt_reg;
   logic                  ovf_cap_reg;
   logic                  ovf_reg;
   logic                  done_reg;
   logic [4*DIGITS-1:0]   bcd_reg;

   logic [4*WD-1:0]       work_adj;
   logic [4*WD+WIDTH-1:0] sh_next;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge Clock) begin
      if (Reset)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = SHIFT;
         SHIFT:   if (cnt_reg == CW'(WIDTH - 1)) state_next = COMMIT;
         COMMIT:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_reg != IDLE);
   end

   // ----------------------------------------------------------- datapath
   // Add 3 to every working digit >= 5 before the shift, so the doubling
   // carries correctly into the next decimal digit.
   generate
      for (genvar gi = 0; gi < WD; gi++) begin : g_adj
         assign work_adj[4*gi +: 4] = (work_reg[4*gi +: 4] >= 4'd5)
                                      ? (work_reg[4*gi +: 4] + 4'd3)
                                      : work_reg[4*gi +: 4];
      end
   endgenerate

   assign sh_next = {work_adj, bin_sh_reg} << 1;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         bin_sh_reg  <= '0;
         work_reg    <= '0;
         cnt_reg     <= '0;
         ovf_cap_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  bin_sh_reg  <= bin;
                  work_reg    <= '0;
                  cnt_reg     <= '0;
                  ovf_cap_reg <= (PW'(bin) >= LIMIT);
               end
            end
            SHIFT: begin
               work_reg   <= sh_next[4*WD+WIDTH-1 -: 4*WD];
               bin_sh_reg <= sh_next[WIDTH-1:0];
               cnt_reg    <= cnt_reg + CW'(1);
            end
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------ committed outputs
   always_ff @(posedge Clock) begin
      if (Reset) begin
         done_reg <= 1'b0;
         ovf_reg  <= 1'b0;
         bcd_reg  <= '0;
      end else begin
         done_reg <= (state_reg == COMMIT);
         if (state_reg == COMMIT) begin
            ovf_reg <= ovf_cap_reg;
            bcd_reg <= work_reg[4*DIGITS-1:0];
         end
      end
   end

   assign done     = done_reg;
   assign overflow = ovf_reg;
   assign bcd      = bcd_reg;

   // One registered display per digit. Display i is blank when it and every
   // digit above it are zero; display 0 is never blanked.
   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_hex
         localparam logic [6:0] RST_SEG = ((gi == 0) || !BLANK_LZ) ? 7'h40 : 7'h7F;

         logic [6:0] seg_next;
         logic [6:0] hex_reg;

         always_comb begin
            if (ovf_cap_reg)
               seg_next = 7'h3F;
            else if (BLANK_LZ && (gi != 0) && (work_reg[4*DIGITS-1:4*gi] == '0))
               seg_next = 7'h7F;
            else
               seg_next = seg7(work_reg[4*gi +: 4]);
         end

         always_ff @(posedge Clock) begin
            if (Reset)
               hex_reg <= RST_SEG;
            else if (state_reg == COMMIT)
               hex_reg <= seg_next;
         end

         assign HEX[7*gi +: 7] = hex_reg;
      end
   endgenerate

endmodule

// File: tb/tb_bin2bcd_hex_seq.sv
module tb_bin2bcd_hex_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] bin;
   logic [7:0]  bin_c;

   logic        busy_a, done_a, ovf_a;
   logic [19:0] bcd_a;
   logic [34:0] hex_a;

   logic        busy_b, done_b, ovf_b;
   logic [19:0] bcd_b;
   logic [34:0] hex_b;

   logic        busy_c, done_c, ovf_c;
   logic [7:0]  bcd_c;
   logic [13:0] hex_c;

   int n_tests = 0;
   int n_fail  = 0;

   assign bin_c = bin[7:0];

   // Defaults (16 bits, 5 digits, blanking on)
   bin2bcd_hex_seq u_dut_a (
      .Clock(clk), .Reset(rst), .start(start), .bin(bin),
      .busy(busy_a), .done(done_a), .overflow(ovf_a), .bcd(bcd_a), .HEX(hex_a)
   );

   // Blanking off
   bin2bcd_hex_seq #(.WIDTH(16), .DIGITS(5), .BLANK_LZ(1'b0)) u_dut_b (
      .Clock(clk), .Reset(rst), .start(start), .bin(bin),
      .busy(busy_b), .done(done_b), .overflow(ovf_b), .bcd(bcd_b), .HEX(hex_b)
   );

   // Narrow: 8 bits, 2 digits (overflow possible)
   bin2bcd_hex_seq #(.WIDTH(8), .DIGITS(2), .BLANK_LZ(1'b1)) u_dut_c (
      .Clock(clk), .Reset(rst), .start(start), .bin(bin_c),
      .busy(busy_c), .done(done_c), .overflow(ovf_c), .bcd(bcd_c), .HEX(hex_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s = %0h", tag, got);
      end
   endtask

   // Waits (bounded) for done_a; lat = edges after the accepting edge, -1 on timeout.
   task automatic wait_done(output int lat, output int busy_cnt);
      lat      = -1;
      busy_cnt = 0;
      for (int k = 1; k <= 40; k++) begin
         if (busy_a) busy_cnt++;
         @(posedge clk); #1;
         if (done_a) begin
            lat = k;
            break;
         end
      end
   endtask

   // Launches one conversion, returns in the cycle where done_a is high.
   task automatic convert(input logic [15:0] v, output int lat, output int busy_cnt);
      @(negedge clk);
      bin   = v;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      bin   = ~v;
      wait_done(lat, busy_cnt);
   endtask

   int lat, bcnt, dones;

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      bin   = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_busy", busy_a, 1'b0);
      check_eq("rst_done", done_a, 1'b0);
      check_eq("rst_ovf",  ovf_a,  1'b0);
      check_eq("rst_bcd",  bcd_a,  20'h00000);
      check_eq("rst_hex_a", hex_a, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
      check_eq("rst_hex_b", hex_b, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40});
      check_eq("rst_hex_c", hex_c, {7'h7F, 7'h40});
      rst = 1'b0;

      // zero
      convert(16'd0, lat, bcnt);
      check_eq("zero_latency", lat, 17);
      check_eq("zero_busy_cycles", bcnt, 17);
      check_eq("zero_bcd", bcd_a, 20'h00000);
      check_eq("zero_ovf", ovf_a, 1'b0);
      check_eq("zero_hex", hex_a, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
      check_eq("zero_hex_c", hex_c, {7'h7F, 7'h40});
      @(posedge clk); #1;
      check_eq("done_one_cycle", done_a, 1'b0);
      check_eq("busy_after_done", busy_a, 1'b0);

      // full scale
      convert(16'd65535, lat, bcnt);
      check_eq("max_latency", lat, 17);
      check_eq("max_busy_cycles", bcnt, 17);
      check_eq("max_bcd", bcd_a, 20'h65535);
      check_eq("max_ovf", ovf_a, 1'b0);
      check_eq("max_hex", hex_a, {7'h02, 7'h12, 7'h12, 7'h30, 7'h12});
      check_eq("c255_ovf", ovf_c, 1'b1);
      check_eq("c255_bcd", bcd_c, 8'h55);
      check_eq("c255_hex", hex_c, {7'h3F, 7'h3F});

      // 42 with and without blanking
      convert(16'd42, lat, bcnt);
      check_eq("b42_bcd", bcd_a, 20'h00042);
      check_eq("b42_hex_a", hex_a, {7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24});
      check_eq("b42_hex_b", hex_b, {7'h40, 7'h40, 7'h40, 7'h19, 7'h24});
      check_eq("c42_bcd", bcd_c, 8'h42);
      check_eq("c42_hex", hex_c, {7'h19, 7'h24});

      // narrow-instance overflow boundary
      convert(16'd99, lat, bcnt);
      check_eq("c99_bcd", bcd_c, 8'h99);
      check_eq("c99_ovf", ovf_c, 1'b0);
      check_eq("c99_hex", hex_c, {7'h18, 7'h18});
      check_eq("a99_hex", hex_a, {7'h7F, 7'h7F, 7'h7F, 7'h18, 7'h18});
      convert(16'd100, lat, bcnt);
      check_eq("c100_ovf", ovf_c, 1'b1);
      check_eq("c100_bcd", bcd_c, 8'h00);
      check_eq("a100_bcd", bcd_a, 20'h00100);
      check_eq("a100_hex", hex_a, {7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40});
      convert(16'd200, lat, bcnt);
      check_eq("c200_ovf", ovf_c, 1'b1);
      check_eq("c200_bcd", bcd_c, 8'h00);
      check_eq("c200_hex", hex_c, {7'h3F, 7'h3F});
      check_eq("a200_bcd", bcd_a, 20'h00200);

      // start while busy is ignored
      @(negedge clk);
      bin   = 16'd100;
      start = 1'b1;
      @(posedge clk); #1;
      dones = 0;
      for (int k = 1; k <= 30; k++) begin
         start = (k == 3) || (k == 10);
         bin   = 16'd7;
         @(posedge clk); #1;
         if (done_a) dones++;
      end
      start = 1'b0;
      check_eq("busy_start_done_count", dones, 1);
      check_eq("busy_start_bcd", bcd_a, 20'h00100);

      // start held in the done cycle is accepted
      convert(16'd9, lat, bcnt);
      check_eq("b9_bcd", bcd_a, 20'h00009);
      start = 1'b1;
      bin   = 16'd7;
      @(posedge clk); #1;
      start = 1'b0;
      bin   = 16'd3;
      wait_done(lat, bcnt);
      check_eq("chain_latency", lat, 17);
      check_eq("chain_bcd", bcd_a, 20'h00007);

      // reset in the middle of a conversion
      @(negedge clk);
      bin   = 16'd12345;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (7) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_eq("abort_busy", busy_a, 1'b0);
      check_eq("abort_done", done_a, 1'b0);
      check_eq("abort_bcd",  bcd_a,  20'h00000);
      check_eq("abort_hex",  hex_a,  {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
      dones = 0;
      for (int k = 0; k < 25; k++) begin
         @(posedge clk); #1;
         if (done_a) dones++;
      end
      check_eq("abort_no_done", dones, 0);
      convert(16'd12345, lat, bcnt);
      check_eq("redo_latency", lat, 17);
      check_eq("redo_bcd", bcd_a, 20'h12345);
      check_eq("redo_hex", hex_a, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12});
      check_eq("c57_bcd", bcd_c, 8'h57);
      check_eq("c57_hex", hex_c, {7'h12, 7'h78});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bin2bcd_hex_seq.md
Name: bin2bcd_hex_seq

Overview:
Parametrised, multi-cycle binary-to-BCD converter with an integrated active-low seven-segment driver. It converts a WIDTH-bit unsigned value into DIGITS BCD digits using iterative shift-and-add-3, one bit per clock. A start/busy/done handshake controls each conversion. It adds overflow detection and optional leading-zero blanking, and it is the wide-input successor to the fixed 6-bit two-digit combinational converter/display path.

Parameters:
WIDTH, 16, input binary width in bits (>=2)
DIGITS, 5, number of BCD digits/HEX displays produced (>=1)
BLANK_LZ, 1, 1 = blank leading zero digits (digit 0 always shown); 0 = show all digits

Ports:
Clock  input  1  system clock, all state on rising edge
Reset  input  1  synchronous, active-high reset
start  input  1  request conversion of bin; sampled only in IDLE
bin  input  WIDTH  unsigned binary value, captured on the accepting edge
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when results update
overflow  output  1  1 = last captured bin >= 10^DIGITS
bcd  output  4*DIGITS  result digits, digit i at [4i+3:4i], digit 0 = ones
HEX  output  7*DIGITS  active-low segments, display i at [7i+6:7i]

Behaviour:
- Interface: one clock (Clock); reset (Reset) is synchronous and active-high.
- Reset: the FSM goes to IDLE; busy=0, done=0, overflow=0, bcd=0.
- HEX after reset is the encoding of value 0:
  - display 0 = 7'h40.
  - other displays = 7'h7F if BLANK_LZ=1, else 7'h40.
- FSM states are IDLE, SHIFT, COMMIT.
  - IDLE: when start=1 on edge E0, capture bin into the shift register, clear the BCD working register and bit counter, compute ovf_next = (bin >= 10^DIGITS), set busy=1, go to SHIFT.
  - SHIFT: on each of edges E1..E_WIDTH, first add 3 to every working BCD digit >=5, then shift the {BCD, bin} register left by one. After WIDTH shifts, go to COMMIT.
  - COMMIT: on edge E_(WIDTH+1), register the outputs and set done=1 for exactly one cycle, busy=0, go to IDLE.
    - bcd <= working digits, truncated to DIGITS when overflowing.
    - overflow <= ovf_next.
    - HEX <= encoded digits.
- Latency: done is high in the cycle after E_(WIDTH+1), i.e. WIDTH+1 clocks after the accepting edge. Throughput is one conversion per WIDTH+2 clocks.
- start while busy=1 is ignored; it is not queued.
- start=1 in the cycle where done=1 is accepted, because the FSM is already in IDLE.
- bin may change freely after the accepting edge.
- bcd, HEX and overflow hold their values between done pulses. They never show intermediate values.
- The constant 10^DIGITS is computed at elaboration. If 10^DIGITS > 2^WIDTH-1, overflow is constant 0.
- Segment encoding (active-low, bit 6 = g) per digit 0..9: 40,79,24,30,19,12,02,78,00,18 (hex). Codes 10..15 cannot occur.
- Overflow display: every display shows dash 7'h3F, regardless of BLANK_LZ.
- Leading-zero blanking (BLANK_LZ=1, no overflow): display i (i>=1) = 7'h7F when digits i..DIGITS-1 are all zero.
- Reset asserted mid-conversion aborts the conversion within the same edge: no done pulse, and outputs return to reset values.
- Reset has priority over start.

Test Plan:
- Defaults; bin=0, start pulse -> done exactly 17 clocks after the accepting edge; bcd=20'h00000, overflow=0, HEX[6:0]=7'h40, HEX[34:7] all 7'h7F.
- Defaults; bin=65535 -> bcd=20'h65535; HEX displays 4..0 = 02,12,12,30,12; busy high for 17 cycles.
- Defaults; bin=42 -> bcd=20'h00042, HEX[6:0]=7'h24, HEX[13:7]=7'h19, displays 2..4 = 7'h7F. Repeat with BLANK_LZ=0 -> displays 2..4 = 7'h40.
- WIDTH=8, DIGITS=2: bin=99 -> bcd=8'h99, overflow=0. Then bin=200 -> overflow=1, both displays 7'h3F, bcd=8'h00.
- Defaults: start at bin=100, then start with bin=7 pulsed on cycles 3 and 10 of busy -> single done, bcd=20'h00100. start held during the done cycle with bin=7 -> next result 20'h00007.
- Defaults: Reset asserted at cycle 8 of a conversion of 12345 -> next cycle busy=0, no done pulse, bcd=0, HEX = reset pattern. A subsequent conversion of 12345 completes normally.
